// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP transmit scheduler.
// Holds the scheduler state encoding, payload limit and requester index type.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SEND,
        GAP
    } sched_state_t;

    localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd1472;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx2oh(input req_idx_t i);
        return {i, ~i};
    endfunction

endpackage

// File: rtl/udp_tx_sched_if.sv
// Scheduler-to-transmitter bundle: start enable, length, IPv4 id, payload
// byte out; busy and byte-load strobe back. master = scheduler side.
interface udp_tx_sched_if;

    logic        O_mac_en;
    logic [15:0] O_mac_len;
    logic [15:0] O_mac_ipv4sign;
    logic [7:0]  O_mac_data;
    logic        I_mac_busy;
    logic        I_mac_load;

    modport master (
        output O_mac_en,
        output O_mac_len,
        output O_mac_ipv4sign,
        output O_mac_data,
        input  I_mac_busy,
        input  I_mac_load
    );

    modport slave (
        input  O_mac_en,
        input  O_mac_len,
        input  O_mac_ipv4sign,
        input  O_mac_data,
        output I_mac_busy,
        output I_mac_load
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; only the preference pointer is a flop.
// Ports: clk_i/rst_ni, req_i, adv_i + served_i (move pointer), gnt_vld_o/gnt_idx_o.
module rr_arb2
    import udp_tx_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic [1:0] req_i,
    input  logic     adv_i,
    input  req_idx_t served_i,
    output logic     gnt_vld_o,
    output req_idx_t gnt_idx_o
);

    // Requester favoured when both ask; the one not served last.
    req_idx_t prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (adv_i) begin
            prio_q <= ~served_i;
        end
    end

    assign gnt_vld_o = |req_i;
    assign gnt_idx_o = (&req_i) ? prio_q : req_i[1];

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin frame scheduler in front of the UDP/IP/MAC transmitter.
// Ports: I_req/I_lenX/I_dataX from requesters; O_rd/O_done/O_err/O_grant back; mac = transmitter.
module udp_tx_sched
    import udp_tx_pkg::*;
#(
    parameter logic [15:0] MAX_LEN        = UDP_MAX_PAYLOAD,
    parameter int unsigned GAP_CYCLES     = 48,
    parameter int unsigned BUSY_TIMEOUT   = 1024,
    parameter logic [15:0] IPV4_SIGN_INIT = 16'h0000
) (
    input  logic        I_clk50m,
    input  logic        I_rst_n,
    input  logic [1:0]  I_req,
    input  logic [15:0] I_len0,
    input  logic [15:0] I_len1,
    input  logic [7:0]  I_data0,
    input  logic [7:0]  I_data1,
    output logic [1:0]  O_rd,
    output logic [1:0]  O_done,
    output logic [1:0]  O_err,
    output logic [1:0]  O_grant,
    udp_tx_sched_if.master mac
);

    localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    sched_state_t state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   done_q, done_d;
    logic [1:0]   err_q, err_d;
    logic [15:0]  len_q, len_d;
    logic [15:0]  sign_q, sign_d;
    logic [15:0]  cnt_q, cnt_d;

    logic         adv;
    req_idx_t     served;
    logic         gnt_vld;
    req_idx_t     gnt_idx;
    logic [15:0]  req_len;
    logic         len_bad;

    rr_arb2 u_arb (
        .clk_i     (I_clk50m),
        .rst_ni    (I_rst_n),
        .req_i     (I_req),
        .adv_i     (adv),
        .served_i  (served),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    assign req_len = gnt_idx ? I_len1 : I_len0;
    assign len_bad = (req_len == 16'd0) || (req_len > MAX_LEN);
    assign served  = (state_q == IDLE) ? gnt_idx : grant_q[1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Hold off while done pulses so the finished
                // requester can drop its level request.
                if (gnt_vld && done_q == 2'b00) begin
                    if (len_bad) begin
                        done_d = idx2oh(gnt_idx);
                        err_d  = idx2oh(gnt_idx);
                        adv    = 1'b1;
                    end else begin
                        grant_d = idx2oh(gnt_idx);
                        len_d   = req_len;
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = 16'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mac.I_mac_busy) begin
                    state_d = SEND;
                end else if (cnt_q == TO_LAST) begin
                    done_d  = grant_q;
                    err_d   = grant_q;
                    grant_d = 2'b00;
                    adv     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SEND: begin
                if (!mac.I_mac_busy) begin
                    done_d  = grant_q;
                    grant_d = 2'b00;
                    sign_d  = sign_q + 16'd1;
                    adv     = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk50m or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            len_q   <= 16'd0;
            sign_q  <= IPV4_SIGN_INIT;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            len_q   <= len_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
        end
    end

    assign O_grant = grant_q;
    assign O_done  = done_q;
    assign O_err   = err_q;
    assign O_rd    = (state_q == SEND) ? ({2{mac.I_mac_load}} & grant_q) : 2'b00;

    assign mac.O_mac_en       = (state_q == WAIT_BUSY);
    assign mac.O_mac_len      = len_q;
    assign mac.O_mac_ipv4sign = sign_q;
    assign mac.O_mac_data     = grant_q[1] ? I_data1 :
                                grant_q[0] ? I_data0 : 8'h00;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: instance A default, instance B wraps sign with no gap.
// A small transmitter model answers mac_en with busy and load strobes.
module tb_udp_tx_sched;

    localparam int GAP = 48;

    typedef struct {
        int          g_at;
        int          en_at;
        int          en_cnt;
        int          d_at;
        logic [1:0]  g;
        logic [15:0] len;
        logic [15:0] sign;
        logic [1:0]  d;
        logic [1:0]  e;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_a, req_b;
    logic [15:0] len0, len1;
    logic [7:0]  data0, data1;
    logic        busy, load;
    logic        phase_b;
    logic        mon_on;
    bit          mute;
    int          blen;
    int          own;
    int          mon_bad = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    logic [1:0]  a_rd, a_done, a_err, a_grant;
    logic [1:0]  b_rd, b_done, b_err, b_grant;

    always #10 clk = ~clk;

    udp_tx_sched_if ifa ();
    udp_tx_sched_if ifb ();

    assign ifa.I_mac_busy = busy;
    assign ifa.I_mac_load = load;
    assign ifb.I_mac_busy = busy;
    assign ifb.I_mac_load = load;

    udp_tx_sched u_a (
        .I_clk50m (clk),
        .I_rst_n  (rst_n),
        .I_req    (req_a),
        .I_len0   (len0),
        .I_len1   (len1),
        .I_data0  (data0),
        .I_data1  (data1),
        .O_rd     (a_rd),
        .O_done   (a_done),
        .O_err    (a_err),
        .O_grant  (a_grant),
        .mac      (ifa)
    );

    udp_tx_sched #(
        .GAP_CYCLES     (0),
        .IPV4_SIGN_INIT (16'hFFFE)
    ) u_b (
        .I_clk50m (clk),
        .I_rst_n  (rst_n),
        .I_req    (req_b),
        .I_len0   (len0),
        .I_len1   (len1),
        .I_data0  (data0),
        .I_data1  (data1),
        .O_rd     (b_rd),
        .O_done   (b_done),
        .O_err    (b_err),
        .O_grant  (b_grant),
        .mac      (ifb)
    );

    wire [1:0]  x_done  = phase_b ? b_done  : a_done;
    wire [1:0]  x_err   = phase_b ? b_err   : a_err;
    wire [1:0]  x_grant = phase_b ? b_grant : a_grant;
    wire        x_en    = phase_b ? ifb.O_mac_en : ifa.O_mac_en;
    wire [15:0] x_len   = phase_b ? ifb.O_mac_len : ifa.O_mac_len;
    wire [15:0] x_sign  = phase_b ? ifb.O_mac_ipv4sign : ifa.O_mac_ipv4sign;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget, output res_t r);
        r.g_at = -1; r.en_at = -1; r.en_cnt = 0; r.d_at = -1;
        r.g = 2'b00; r.len = 16'd0; r.sign = 16'd0;
        r.d = 2'b00; r.e = 2'b00;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            #1;
            if (x_grant != 2'b00 && r.g_at < 0) begin
                r.g_at = c; r.g = x_grant; r.len = x_len;
            end
            if (x_en) begin
                if (r.en_at < 0) r.en_at = c;
                r.en_cnt++;
                r.sign = x_sign;
            end
            if (x_done != 2'b00) begin
                r.d_at = c; r.d = x_done; r.e = x_err;
                break;
            end
        end
        if (r.d_at < 0) chk("done_wait", 32'd0, 32'd1);
        if (phase_b) req_b = req_b & ~r.d;
        else req_a = req_a & ~r.d;
    endtask

    // Transmitter model: busy two negedges after en is seen, held blen clocks.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && !mute && (ifa.O_mac_en || ifb.O_mac_en)) begin
            repeat (2) @(negedge clk);
            busy = 1'b1;
            for (int i = 0; i < blen && rst_n; i++) begin
                @(negedge clk);
                load = (i % 3 == 1);
            end
            load = 1'b0;
            busy = 1'b0;
        end
    end

    // Byte strobe and data routing monitor.
    initial forever begin
        @(negedge clk);
        #2;
        if (mon_on && rst_n === 1'b1) begin
            logic [1:0] e;
            e = load ? ((own != 0) ? 2'b10 : 2'b01) : 2'b00;
            if (phase_b) begin
                if (b_rd !== e || a_rd !== 2'b00) mon_bad++;
                if (load && ifb.O_mac_data !== ((own != 0) ? data1 : data0)) mon_bad++;
            end else begin
                if (a_rd !== e || b_rd !== 2'b00) mon_bad++;
                if (load && ifa.O_mac_data !== ((own != 0) ? data1 : data0)) mon_bad++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        logic [1:0]  acc;
        logic [1:0]  eg;
        logic [15:0] exp_s [3];

        exp_s[0] = 16'hFFFE; exp_s[1] = 16'hFFFF; exp_s[2] = 16'h0000;
        rst_n = 1'b0; req_a = 2'b00; req_b = 2'b00;
        len0 = 16'd0; len1 = 16'd0; data0 = 8'h5A; data1 = 8'hA5;
        busy = 1'b0; load = 1'b0; phase_b = 1'b0; mon_on = 1'b0;
        mute = 1'b0; blen = 40; own = 0;
        cyc(3);

        chk("rst_out", {23'd0, a_grant, a_rd, a_done, a_err, ifa.O_mac_en}, 32'd0);
        chk("rst_len", ifa.O_mac_len, 32'd0);
        chk("rst_sign", ifa.O_mac_ipv4sign, 32'h0000);
        chk("rst_sign_b", ifb.O_mac_ipv4sign, 32'hFFFE);
        chk("rst_data", ifa.O_mac_data, 32'd0);
        rst_n = 1'b1;
        cyc(2);
        load = 1'b1;
        cyc(1);
        chk("idle_load", a_rd, 32'd0);
        load = 1'b0;
        mon_on = 1'b1;
        cyc(2);

        // both requesting: 0,1,0,1 with the full gap between frames
        len0 = 16'd222; len1 = 16'd222; blen = 30; req_a = 2'b11;
        for (int k = 0; k < 4; k++) begin
            own = k % 2;
            eg = (k % 2 != 0) ? 2'b10 : 2'b01;
            wait_done(400, r);
            chk("alt_grant", r.g, eg);
            chk("alt_done", r.d, eg);
            chk("alt_gap", r.g_at, (k == 0) ? 1 : GAP);
            if (k < 3) begin
                cyc(1);
                req_a = 2'b11;
            end
        end
        req_a = 2'b00;
        chk("alt_sign", ifa.O_mac_ipv4sign, 32'd4);
        cyc(60);

        // single long frame
        len0 = 16'd1145; blen = 1200; own = 0; req_a = 2'b01;
        wait_done(1500, r);
        chk("one_g_at", r.g_at, 32'd1);
        chk("one_grant", r.g, 32'b01);
        chk("one_len", r.len, 32'd1145);
        chk("one_en_at", r.en_at, 32'd2);
        chk("one_en_cnt", r.en_cnt, 32'd3);
        chk("one_sign_en", r.sign, 32'd4);
        chk("one_d_at", r.d_at, 32'd1205);
        chk("one_done", r.d, 32'b01);
        chk("one_err", r.e, 32'b00);
        chk("one_gnt_clr", a_grant, 32'd0);
        chk("one_sign", ifa.O_mac_ipv4sign, 32'd5);
        cyc(60);

        // illegal lengths, then the largest legal one
        len1 = 16'd0; own = 1; req_a = 2'b10;
        wait_done(20, r);
        chk("bad0_d_at", r.d_at, 32'd1);
        chk("bad0_done", r.d, 32'b10);
        chk("bad0_err", r.e, 32'b10);
        chk("bad0_en", r.en_cnt, 32'd0);
        chk("bad0_gnt", r.g_at, 32'hFFFF_FFFF);
        cyc(2);
        len1 = 16'd1500; req_a = 2'b10;
        wait_done(20, r);
        chk("bad1_done", r.d, 32'b10);
        chk("bad1_err", r.e, 32'b10);
        chk("bad1_en", r.en_cnt, 32'd0);
        chk("bad_len_keep", ifa.O_mac_len, 32'd1145);
        chk("bad_sign", ifa.O_mac_ipv4sign, 32'd5);
        cyc(2);
        len1 = 16'd1472; blen = 20; req_a = 2'b10;
        wait_done(200, r);
        chk("max_len", r.len, 32'd1472);
        chk("max_done", r.d, 32'b10);
        chk("max_err", r.e, 32'b00);
        cyc(60);

        // busy never rises
        mute = 1'b1; len0 = 16'd100; own = 0; req_a = 2'b01;
        wait_done(1200, r);
        chk("to_en_at", r.en_at, 32'd2);
        chk("to_dist", r.d_at - r.en_at, 32'd1024);
        chk("to_en_cnt", r.en_cnt, 32'd1024);
        chk("to_done", r.d, 32'b01);
        chk("to_err", r.e, 32'b01);
        chk("to_gnt_clr", a_grant, 32'd0);
        chk("to_sign", ifa.O_mac_ipv4sign, 32'd6);
        mute = 1'b0;
        cyc(4);
        blen = 25; req_a = 2'b01;
        wait_done(300, r);
        chk("post_to_done", r.d, 32'b01);
        chk("post_to_err", r.e, 32'b00);
        chk("post_to_sign", ifa.O_mac_ipv4sign, 32'd7);
        cyc(60);

        // reset in the middle of a frame from requester 1
        len1 = 16'd300; blen = 200; own = 1; req_a = 2'b10;
        cyc(20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {23'd0, a_grant, a_rd, a_done, a_err, ifa.O_mac_en}, 32'd0);
        chk("mid_rst_len", ifa.O_mac_len, 32'd0);
        chk("mid_rst_sign", ifa.O_mac_ipv4sign, 32'd0);
        cyc(3);
        req_a = 2'b00;
        rst_n = 1'b1;
        acc = 2'b00;
        repeat (5) begin
            cyc(1);
            acc = acc | a_done;
        end
        chk("mid_rst_nodone", acc, 32'd0);
        len0 = 16'd64; len1 = 16'd64; blen = 20; own = 0; req_a = 2'b11;
        wait_done(300, r);
        req_a = 2'b00;
        chk("mid_rst_ptr", r.g, 32'b01);
        chk("mid_rst_sign_en", r.sign, 32'd0);
        cyc(60);

        // instance B: sign wrap, no gap
        phase_b = 1'b1; len0 = 16'd100; blen = 10; own = 0; req_b = 2'b01;
        for (int k = 0; k < 3; k++) begin
            wait_done(200, r);
            chk("wrap_sign", r.sign, {16'd0, exp_s[k]});
            chk("wrap_done", r.d, 32'b01);
            if (k > 0) chk("wrap_nogap", r.g_at, 32'd1);
            if (k < 2) begin
                cyc(1);
                req_b = 2'b01;
            end
        end
        chk("wrap_final", x_sign, 32'd1);
        cyc(5);
        chk("rd_mirror", mon_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Two-requester scheduler in front of the UDP/IP/MAC transmitter; runs on the 50 MHz RMII clock.
- Arbitrates frame requests round-robin and drives the transmitter's enable, length and IPv4 identification inputs.
- Routes the transmitter's byte-load strobe and data back to the granted requester.
- Enforces an inter-frame gap and reports done/error per requester.

Parameters:
- MAX_LEN, 16'd1472, largest legal UDP payload length in bytes.
- GAP_CYCLES, 48, idle clocks after transmitter busy falls before the next grant (0 = no gap).
- BUSY_TIMEOUT, 1024, clocks allowed for transmitter busy to rise after enable.
- IPV4_SIGN_INIT, 16'h0000, reset value of the IPv4 identification counter.

Ports:
- I_clk50m  in  1  RMII 50 MHz clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_req  in  2  per-requester frame request, level; held until the matching O_done.
- I_len0, I_len1  in  16 each  payload length of requester 0/1; stable while its I_req is high.
- I_data0, I_data1  in  8 each  payload byte of requester 0/1.
- O_rd  out  2  per-requester byte strobe.
- O_done  out  2  one-clock completion pulse per requester.
- O_err  out  2  one-clock error pulse per requester, coincident with O_done.
- O_grant  out  2  one-hot current owner; 0 when idle.
- O_mac_en  out  1  transmitter start enable.
- O_mac_len  out  16  payload length to transmitter.
- O_mac_ipv4sign  out  16  IPv4 identification to transmitter.
- O_mac_data  out  8  payload byte to transmitter.
- I_mac_busy  in  1  transmitter busy.
- I_mac_load  in  1  transmitter is consuming a payload byte this clock.

Behaviour:
- Reset (async, I_rst_n=0):
  - State IDLE; round-robin pointer to requester 0.
  - O_grant, O_rd, O_done, O_err, O_mac_en = 0; O_mac_len = 0.
  - Sign counter = IPV4_SIGN_INIT.
  - Reset mid-frame aborts silently; no done or error pulse.
- States IDLE, START, WAIT_BUSY, SEND, GAP.
- IDLE:
  - If any I_req is high, grant it. If both are high, grant the requester other than the last one served.
  - Register O_grant and O_mac_len from the granted I_lenX, then go to START.
  - If the granted length is 0 or > MAX_LEN: pulse O_done and O_err for that requester next clock, advance the pointer, stay in IDLE, and do not touch the transmitter.
- START: one setup clock with len and sign stable; O_mac_en = 0. Next state WAIT_BUSY.
- WAIT_BUSY:
  - O_mac_en = 1 while here.
  - When I_mac_busy = 1, go to SEND; O_mac_en drops on that registered edge.
  - After BUSY_TIMEOUT clocks without busy: pulse O_done and O_err, clear grant, advance the pointer, go to IDLE. Sign is not incremented.
- SEND:
  - O_rd[g] = I_mac_load & O_grant[g] (combinational).
  - O_mac_data = data of the granted requester (combinational mux; 8'h00 when idle).
  - When I_mac_busy = 0: go to GAP, pulse O_done[g] on the next clock, increment the sign (16'hFFFF wraps to 16'h0000), advance the pointer.
  - A requester dropping I_req mid-frame does not abort; the frame completes and done still pulses.
- GAP:
  - O_grant = 0.
  - Count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES = 0, SEND goes straight to IDLE.
- Latency: a request sampled in IDLE at cycle N gives O_grant at N+1 (START) and O_mac_en at N+2.
- I_mac_load outside SEND is ignored: O_rd = 0.

Decomposition:
- Package udp_tx_pkg holds:
  - state enum sched_state_t {IDLE, START, WAIT_BUSY, SEND, GAP};
  - constant UDP_MAX_PAYLOAD = 1472;
  - requester-index typedef.
- Sub-module rr_arb2: two-input round-robin arbiter with a last-served pointer and an advance input. It is combinational except for the pointer flop.

Test Plan:
- Single request: I_req=01, I_len0=1145, busy rises 3 clocks after en and stays high 1200 clocks -> O_mac_en high 3 clocks from N+2, O_mac_len=1145, O_rd[0] mirrors I_mac_load, O_done[0] one pulse, sign 0->1.
- Simultaneous requests: I_req=11 held, both lengths 222 -> grants alternate 0,1,0,1; each consecutive frame separated by ≥48 idle clocks after busy falls.
- Bad length: I_len1=0 then I_len1=1500 -> O_done[1] and O_err[1] pulse together, O_mac_en never asserted, sign unchanged.
- Timeout: busy held 0 -> O_err pulse exactly 1024 clocks after en rises, then IDLE; the next request proceeds normally.
- Sign wrap: IPV4_SIGN_INIT=16'hFFFE, three good frames -> O_mac_ipv4sign sequence FFFE, FFFF, 0000.
- Reset mid-frame: assert I_rst_n=0 during SEND -> all outputs 0 immediately, no done pulse; after release the pointer is at requester 0 and the sign equals IPV4_SIGN_INIT.
